// File: rtl/id_operand_unit.sv
// rtl/id_operand_unit.sv - decode-stage register file, load-use hazard detection and stall counter
module id_operand_unit #(
  parameter int DATA_WIDTH          = 32,
  parameter int REGISTER_ADDR_WIDTH = 5
) (
  input  logic                           cpu_clk,
  input  logic                           cpu_rst_n,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rs1_ID_i,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rs2_ID_i,
  input  logic                           uses_rs1_ID_i,
  input  logic                           uses_rs2_ID_i,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX_i,
  input  logic [1:0]                     result_sel_EX_i,
  input  logic                           pc_src_EX_i,
  input  logic                           reg_write_WB_i,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rd_WB_i,
  input  logic [DATA_WIDTH-1:0]          result_WB_i,
  input  logic                           clear_cnt_i,
  output logic [DATA_WIDTH-1:0]          RD1D_o,
  output logic [DATA_WIDTH-1:0]          RD2D_o,
  output logic                           stall_IF_o,
  output logic                           stall_IF_ID_o,
  output logic                           flush_IF_ID_o,
  output logic                           flush_ID_EX_o,
  output logic [31:0]                    stall_cnt_o
);

  localparam int NUM_REGS = 1 << REGISTER_ADDR_WIDTH;
  localparam logic [1:0] RESULT_SEL_LOAD = 2'b01;

  // x0 is hardwired to zero, so storage starts at index 1
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS-1:1];
  logic [31:0]           stall_cnt_q;
  logic [31:0]           stall_cnt_d;

  logic wb_write;
  logic load_use;
  logic rs1_hit;
  logic rs2_hit;
  logic stall;

  assign wb_write = reg_write_WB_i && (rd_WB_i != '0);

  // Read port: x0 reads zero, an in-flight writeback to the same index is bypassed
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [REGISTER_ADDR_WIDTH-1:0] idx);
    logic [DATA_WIDTH-1:0] val;
    if (idx == '0) begin
      val = '0;
    end else if (wb_write && (rd_WB_i == idx)) begin
      val = result_WB_i;
    end else begin
      val = regs_q[idx];
    end
    return val;
  endfunction

  assign RD1D_o = read_port(rs1_ID_i);
  assign RD2D_o = read_port(rs2_ID_i);

  // Register file storage: async clear, writes to x0 dropped
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_write) begin
      regs_q[rd_WB_i] <= result_WB_i;
    end
  end

  // Load-use detection: a load in EX whose destination feeds a source read in ID
  always_comb begin
    rs1_hit  = uses_rs1_ID_i && (rd_EX_i == rs1_ID_i);
    rs2_hit  = uses_rs2_ID_i && (rd_EX_i == rs2_ID_i);
    load_use = (result_sel_EX_i == RESULT_SEL_LOAD) && (rd_EX_i != '0) && (rs1_hit || rs2_hit);
  end

  // A redirect squashes the dependent instruction anyway, so it overrides the stall
  assign stall         = load_use && !pc_src_EX_i;
  assign stall_IF_o    = stall;
  assign stall_IF_ID_o = stall;
  assign flush_IF_ID_o = pc_src_EX_i;
  assign flush_ID_EX_o = load_use || pc_src_EX_i;

  // Stall counter next state: clear wins, increment saturates at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clear_cnt_i) begin
      stall_cnt_d = '0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_operand_unit.sv
// tb/tb_id_operand_unit.sv - directed scoreboard bench for id_operand_unit
module tb_id_operand_unit;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1, rs2, rd_ex, rd_wb;
  logic        u1, u2, pc_src, rw, clr;
  logic [1:0]  rsel;
  logic [31:0] res_wb;
  logic [31:0] rd1, rd2, cnt;
  logic        st_if, st_ifid, fl_ifid, fl_idex;

  int tests = 0;
  int fails = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  id_operand_unit #(.DATA_WIDTH(32), .REGISTER_ADDR_WIDTH(5)) dut (
    .cpu_clk         (clk),
    .cpu_rst_n       (rst_n),
    .rs1_ID_i        (rs1),
    .rs2_ID_i        (rs2),
    .uses_rs1_ID_i   (u1),
    .uses_rs2_ID_i   (u2),
    .rd_EX_i         (rd_ex),
    .result_sel_EX_i (rsel),
    .pc_src_EX_i     (pc_src),
    .reg_write_WB_i  (rw),
    .rd_WB_i         (rd_wb),
    .result_WB_i     (res_wb),
    .clear_cnt_i     (clr),
    .RD1D_o          (rd1),
    .RD2D_o          (rd2),
    .stall_IF_o      (st_if),
    .stall_IF_ID_o   (st_ifid),
    .flush_IF_ID_o   (fl_ifid),
    .flush_ID_EX_o   (fl_idex),
    .stall_cnt_o     (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_v(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check_v(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic expect_hz(input string n, input logic st, input logic fi, input logic fe);
    expect_v({n, "_stall_IF"}, {31'd0, st});
    expect_v({n, "_stall_IF_ID"}, {31'd0, st});
    expect_v({n, "_flush_IF_ID"}, {31'd0, fi});
    expect_v({n, "_flush_ID_EX"}, {31'd0, fe});
  endtask

  task automatic check_hz();
    check_v({31'd0, st_if});
    check_v({31'd0, st_ifid});
    check_v({31'd0, fl_ifid});
    check_v({31'd0, fl_idex});
  endtask

  initial begin
    rst_n = 1'b0; rs1 = 5'd5; rs2 = '0; rd_ex = '0; rd_wb = '0;
    u1 = 0; u2 = 0; pc_src = 0; rw = 0; clr = 0; rsel = '0; res_wb = '0;

    // reset state
    #2;
    expect_v("reset_cnt", 32'd0);
    expect_v("reset_rd1", 32'd0);
    check_v(cnt);
    check_v(rd1);

    // write x5, read back next cycle
    @(negedge clk);
    rst_n = 1'b1;
    rw = 1; rd_wb = 5'd5; res_wb = 32'h1234_5678;
    @(negedge clk);
    rw = 0; rs1 = 5'd5; rs2 = 5'd0;
    expect_v("x5_read", 32'h1234_5678);
    expect_v("x0_read", 32'd0);
    #2; check_v(rd1); check_v(rd2);

    // same-cycle bypass on x7
    @(negedge clk);
    rw = 1; rd_wb = 5'd7; res_wb = 32'hA;
    @(negedge clk);
    rw = 0; rs2 = 5'd7;
    expect_v("x7_stored_A", 32'hA);
    #2; check_v(rd2);
    @(negedge clk);
    rw = 1; rd_wb = 5'd7; res_wb = 32'hB;
    expect_v("x7_bypass_B", 32'hB);
    #2; check_v(rd2);
    @(negedge clk);
    rw = 1; rd_wb = 5'd0; res_wb = 32'hFF; rs1 = 5'd0;
    expect_v("x7_stored_B", 32'hB);
    expect_v("x0_bypass_blocked", 32'd0);
    #2; check_v(rd2); check_v(rd1);
    @(negedge clk);
    rw = 0;
    expect_v("x0_after_write", 32'd0);
    #2; check_v(rd1);

    // load-use on rs1
    @(negedge clk);
    rsel = 2'b01; rd_ex = 5'd3; rs1 = 5'd3; u1 = 1;
    expect_hz("lu_rs1", 1, 0, 1);
    expect_v("lu_rs1_cnt_before", 32'd0);
    #2; check_hz(); check_v(cnt);
    @(negedge clk);
    rsel = 2'b00;
    expect_hz("bubble", 0, 0, 0);
    expect_v("lu_rs1_cnt_after", 32'd1);
    #2; check_hz(); check_v(cnt);

    // no-stall variants
    @(negedge clk);
    rsel = 2'b01; u1 = 0;
    expect_hz("lu_uses_off", 0, 0, 0);
    #2; check_hz();
    @(negedge clk);
    u1 = 1; rd_ex = 5'd0; rs1 = 5'd0;
    expect_hz("lu_rd_zero", 0, 0, 0);
    #2; check_hz();
    @(negedge clk);
    rsel = 2'b10; rd_ex = 5'd3; rs1 = 5'd3;
    expect_hz("non_load", 0, 0, 0);
    expect_v("non_load_cnt", 32'd1);
    #2; check_hz(); check_v(cnt);

    // load-use on rs2
    @(negedge clk);
    rsel = 2'b01; u1 = 0; rs1 = 5'd0; u2 = 1; rs2 = 5'd3;
    expect_hz("lu_rs2", 1, 0, 1);
    #2; check_hz();

    // redirect overrides the stall
    @(negedge clk);
    pc_src = 1;
    expect_hz("lu_redirect", 0, 1, 1);
    expect_v("lu_redirect_cnt", 32'd2);
    #2; check_hz(); check_v(cnt);
    @(negedge clk);
    rsel = 2'b00; u2 = 0;
    expect_hz("redirect_only", 0, 1, 1);
    expect_v("redirect_cnt_unchanged", 32'd2);
    #2; check_hz(); check_v(cnt);

    // saturation
    @(negedge clk);
    pc_src = 0;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    rsel = 2'b01; rd_ex = 5'd3; rs1 = 5'd3; u1 = 1;
    expect_v("sat_preset", 32'hFFFF_FFFE);
    #1; check_v(cnt);
    @(negedge clk);
    expect_v("sat_first", 32'hFFFF_FFFF);
    #2; check_v(cnt);
    @(negedge clk);
    expect_v("sat_hold", 32'hFFFF_FFFF);
    #2; check_v(cnt);
    clr = 1;
    @(negedge clk);
    clr = 0; rsel = 2'b00; u1 = 0;
    expect_v("clear_wins", 32'd0);
    #2; check_v(cnt);

    // populate x1..x31
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      rw = 1; rd_wb = 5'(i); res_wb = 32'hA5A5_0000 + 32'(i);
    end
    @(negedge clk);
    rw = 0; rs1 = 5'd31; rs2 = 5'd1;
    rsel = 2'b01; rd_ex = 5'd31; u1 = 1;
    expect_v("pop_x31", 32'hA5A5_001F);
    expect_v("pop_x1", 32'hA5A5_0001);
    #2; check_v(rd1); check_v(rd2);
    @(negedge clk);
    rsel = 2'b00; u1 = 0;
    expect_v("pre_reset_cnt", 32'd1);
    #2; check_v(cnt);

    // asynchronous reset between edges with a pending write
    @(posedge clk);
    #2;
    rw = 1; rd_wb = 5'd9; res_wb = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    #1;
    expect_v("async_rst_cnt", 32'd0);
    check_v(cnt);
    rw = 0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      expect_v($sformatf("rst_rd1_x%0d", i), 32'd0);
      expect_v($sformatf("rst_rd2_x%0d", 31 - i), 32'd0);
      #1; check_v(rd1); check_v(rd2);
    end
    rw = 1;
    @(negedge clk);
    rw = 0;
    rst_n = 1'b1;
    @(negedge clk);
    rs1 = 5'd9;
    expect_v("discarded_write_x9", 32'd0);
    expect_v("post_reset_cnt", 32'd0);
    #2; check_v(rd1); check_v(cnt);

    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    fails++;
    $display("FAIL timeout observed=running expected=finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
